// File: rtl/bnn_frame_loader.sv
// Serial-to-row packer that fills BNN input memory MEM0 with one binarised frame,
// kicks off the BNN, and captures the resulting class index.
module bnn_frame_loader #(
  parameter int ROW_W = 28,
  parameter int ROWS  = 48,
  parameter int AW    = 6,
  parameter int CW    = 4
) (
  input  logic             iCLK,
  input  logic             iRSTn,
  input  logic             iCLR,
  input  logic             iBIT,
  input  logic             iBIT_VALID,
  input  logic             iSOF,
  output logic             oBIT_READY,
  output logic [AW-1:0]    oMEM0WrADDR,
  output logic [ROW_W-1:0] oMEM0WrDATA,
  output logic             oMEM0Wr_EN,
  output logic             oSTART,
  input  logic             iDONE,
  input  logic [CW-1:0]    iCLASS,
  output logic [CW-1:0]    oCLASS,
  output logic             oCLASS_VALID,
  output logic             oBUSY,
  output logic             oERR
);

  localparam int BW = $clog2(ROW_W);

  typedef enum logic [1:0] {IDLE, LOAD, START, BUSY} state_t;

  state_t           state_reg, state_next;
  logic [BW-1:0]    bit_cnt_reg;
  logic [AW-1:0]    row_cnt_reg;
  logic [ROW_W-1:0] shift_reg;
  logic             ready_reg, wr_en_reg, start_reg, class_valid_reg, err_reg, done_d_reg;
  logic [AW-1:0]    wr_addr_reg;
  logic [ROW_W-1:0] wr_data_reg;
  logic [CW-1:0]    class_reg;

  logic             accept, restart, row_end, last_row, done_rise;
  logic [ROW_W-1:0] packed_row;

  always_comb begin
    accept     = iBIT_VALID && ready_reg;
    restart    = accept && iSOF;
    row_end    = accept && !iSOF && (state_reg == LOAD) && (bit_cnt_reg == BW'(ROW_W - 1));
    last_row   = (row_cnt_reg == AW'(ROWS - 1));
    done_rise  = iDONE && !done_d_reg;
    packed_row = {shift_reg[ROW_W-2:0], iBIT};

    state_next = state_reg;
    case (state_reg)
      IDLE:  if (restart) state_next = LOAD;
      LOAD:  if (row_end && last_row) state_next = START;
      START: state_next = BUSY;
      BUSY:  if (done_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_reg <= IDLE;
    end else if (iCLR) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      bit_cnt_reg     <= '0;
      row_cnt_reg     <= '0;
      shift_reg       <= '0;
      ready_reg       <= 1'b0;
      wr_en_reg       <= 1'b0;
      start_reg       <= 1'b0;
      class_valid_reg <= 1'b0;
      err_reg         <= 1'b0;
      done_d_reg      <= 1'b0;
      wr_addr_reg     <= '0;
      wr_data_reg     <= '0;
      class_reg       <= '0;
    end else if (iCLR) begin
      bit_cnt_reg     <= '0;
      row_cnt_reg     <= '0;
      shift_reg       <= '0;
      ready_reg       <= 1'b0;
      wr_en_reg       <= 1'b0;
      start_reg       <= 1'b0;
      class_valid_reg <= 1'b0;
      err_reg         <= 1'b0;
      done_d_reg      <= 1'b0;
      wr_addr_reg     <= '0;
      wr_data_reg     <= '0;
      class_reg       <= '0;
    end else begin
      wr_en_reg       <= 1'b0;
      class_valid_reg <= 1'b0;
      start_reg       <= (state_reg == START);
      done_d_reg      <= iDONE;
      ready_reg       <= (state_next == IDLE) || (state_next == LOAD);

      // An SOF beat always (re)starts the frame; in LOAD it also flags the abort.
      if (restart) begin
        bit_cnt_reg <= BW'(1);
        row_cnt_reg <= '0;
        shift_reg   <= {{(ROW_W-1){1'b0}}, iBIT};
        if (state_reg == LOAD) err_reg <= 1'b1;
      end else if (accept && state_reg == LOAD) begin
        shift_reg <= packed_row;
        if (row_end) begin
          bit_cnt_reg <= '0;
          wr_en_reg   <= 1'b1;
          wr_addr_reg <= row_cnt_reg;
          wr_data_reg <= packed_row;
          row_cnt_reg <= last_row ? '0 : row_cnt_reg + AW'(1);
        end else begin
          bit_cnt_reg <= bit_cnt_reg + BW'(1);
        end
      end

      if (state_reg == BUSY && done_rise) begin
        class_reg       <= iCLASS;
        class_valid_reg <= 1'b1;
      end
    end
  end

  assign oBIT_READY   = ready_reg;
  assign oMEM0Wr_EN   = wr_en_reg;
  assign oMEM0WrADDR  = wr_addr_reg;
  assign oMEM0WrDATA  = wr_data_reg;
  assign oSTART       = start_reg;
  assign oCLASS       = class_reg;
  assign oCLASS_VALID = class_valid_reg;
  assign oERR         = err_reg;
  assign oBUSY        = (state_reg != IDLE);

endmodule
